ysyx_22041207_pipe_skid_stage: RTL and testbench
================================================

// Module: ysyx_22041207_pipe_skid_stage
// PURPOSE
//  Generic pipeline-stage register with valid/ready handshake and optional 2-entry skid buffer.
//  Replaces hand-written per-stage registers (IF/ID, ID/EX, EX/ME, ME/WB).
//  Each stage packs its control and data fields into one DATA_W-bit payload.
//  Adds backpressure without a combinational ready path, synchronous flush, and a stall counter.
// PARAMETERS
//  DATA_W   64*4+32  payload width in bits, >=1
//  SKID_EN  1        1: 2-entry skid buffer, registered in_ready; 0: single register, combinational ready
//  CNT_W    16       width of the saturating stall counter, >=1
// PORTS
//  clk          in   1        clock; all state changes on rising edge
//  rst_n        in   1        asynchronous active-low reset
//  flush        in   1        synchronous kill of all held entries
//  in_valid     in   1        upstream payload valid
//  in_ready     out  1        stage can accept this cycle
//  in_data      in   DATA_W   upstream payload
//  out_valid    out  1        downstream payload valid
//  out_ready    in   1        downstream accepts this cycle
//  out_data     out  DATA_W   downstream payload, registered
//  occupancy    out  2        entries held: 0, 1 or 2
//  stall_cnt    out  CNT_W    cycles with out_valid && !out_ready
// BEHAVIOUR
//  Transfer definitions: acc = in_valid & in_ready; pop = out_valid & out_ready.
//  State is given by occupancy: EMPTY (0), ONE (main valid), FULL (main + skid valid).
//  out_valid = main_valid; out_data = main_data.
//  - No combinational path from any input to out_valid or out_data.
//  SKID_EN=1: in_ready = (occupancy != 2), a function of state only.
//  SKID_EN=0: in_ready = !main_valid | out_ready.
//  - FULL is unreachable when SKID_EN=0.
//  Transitions when flush=0:
//  - EMPTY: acc -> ONE, main <= in_data.
//  - ONE: acc & pop -> ONE, main <= in_data.
//  - ONE: acc & !pop -> FULL, skid <= in_data.
//  - ONE: pop & !acc -> EMPTY.
//  - ONE: neither -> hold.
//  - FULL: in_ready = 0; pop -> ONE, main <= skid.
//  - FULL: no pop -> hold.
//  Latency: 1 cycle from acc to out_valid. Full throughput (1 beat/cycle) when out_ready = 1.
//  Ordering is strict FIFO. No payload is dropped or duplicated except by flush.
//  Zero-payload rule: main_data and skid_data are cleared to 0 whenever their entry becomes invalid.
//  - So out_data = 0 whenever out_valid = 0; this is the bubble encoding.
//  flush=1 (highest priority):
//  - Next state is EMPTY with all payloads 0.
//  - Any acc or pop in that cycle is void.
//  - Upstream must flush its own copy of the beat.
//  stall_cnt:
//  - Increments each cycle out_valid & !out_ready, saturating at all-ones.
//  - Not cleared by flush; cleared only by reset.
//  Reset (rst_n = 0, asynchronous, immediate):
//  - occupancy = 0, out_valid = 0, out_data = 0, skid = 0, stall_cnt = 0.
//  - in_ready = 1 (both modes).
//  - Reset mid-operation discards all held beats.
//  Simultaneous flush with reset: reset wins.
// TESTING
//  1. Stream with out_ready = 1, in_data 1,2,3,4 on consecutive cycles
//     -> out_data 1,2,3,4 starting 1 cycle later, no gaps, occupancy stays 1.
//  2. out_ready = 0, send 0xA,0xB,0xC -> A and B accepted, in_ready = 0 from the cycle after B, C held.
//     Raise out_ready -> A,B,C emitted in order. stall_cnt equals the stalled cycles.
//  3. FULL (A,B) plus in_valid with flush = 1 for one cycle -> next cycle occupancy = 0,
//     out_valid = 0, out_data = 0, in_ready = 1, stall_cnt unchanged.
//  4. Assert rst_n = 0 asynchronously mid-cycle while FULL -> outputs reach reset values
//     before the next edge. Deassert, send 5 -> out_data = 5 after 1 cycle.
//  5. SKID_EN = 0, ONE state, toggle out_ready -> in_ready equals out_ready in the same cycle;
//     occupancy never 2.
//  6. CNT_W = 4, hold out_valid with out_ready = 0 for 20 cycles -> stall_cnt = 15 and stays 15.

Source files
------------

// File: rtl/ysyx_22041207_pipe_skid_stage.sv
// Generic pipeline-stage register with valid/ready handshake.
// SKID_EN=1: two entries (main + skid), in_ready depends on state only.
// SKID_EN=0: one entry, in_ready = empty | out_ready (combinational).
// Payload slots are zeroed whenever they become invalid, so a bubble reads as 0.
module ysyx_22041207_pipe_skid_stage #(
   parameter int DATA_W  = 64*4+32,
   parameter int SKID_EN = 1,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic [DATA_W-1:0] main_data, main_nxt;
   logic [DATA_W-1:0] skid_data, skid_nxt;
   logic              acc, pop;

   // Outputs come straight from registers; only in_ready may be combinational.
   assign out_valid = (state != EMPTY);
   assign out_data  = main_data;
   assign occupancy = state;

   generate
      if (SKID_EN != 0) begin : g_skid
         assign in_ready = (state != FULL);
      end else begin : g_noskid
         assign in_ready = (state == EMPTY) | out_ready;
      end
   endgenerate

   assign acc = in_valid & in_ready;
   assign pop = out_valid & out_ready;

   // State and payload registers; async reset discards everything held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= EMPTY;
         main_data <= '0;
         skid_data <= '0;
      end else begin
         state     <= state_nxt;
         main_data <= main_nxt;
         skid_data <= skid_nxt;
      end
   end

   // Next-state: flush wins over any transfer; otherwise strict FIFO moves.
   always_comb begin
      state_nxt = state;
      main_nxt  = main_data;
      skid_nxt  = skid_data;
      if (flush) begin
         state_nxt = EMPTY;
         main_nxt  = '0;
         skid_nxt  = '0;
      end else begin
         case (state)
            EMPTY: begin
               if (acc) begin
                  state_nxt = ONE;
                  main_nxt  = in_data;
               end
            end
            ONE: begin
               if (acc && pop) begin
                  main_nxt = in_data;
               end else if (acc && (SKID_EN != 0)) begin
                  state_nxt = FULL;
                  skid_nxt  = in_data;
               end else if (pop) begin
                  state_nxt = EMPTY;
                  main_nxt  = '0;
               end
            end
            FULL: begin
               if (pop) begin
                  state_nxt = ONE;
                  main_nxt  = skid_data;
                  skid_nxt  = '0;
               end
            end
            default: begin
               state_nxt = EMPTY;
               main_nxt  = '0;
               skid_nxt  = '0;
            end
         endcase
      end
   end

   // Saturating count of cycles where downstream holds off a valid beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_ysyx_22041207_pipe_skid_stage.sv
// Bench for the pipe skid stage: a vector table for streaming/stall/flush,
// hand sequences for async reset, the no-skid variant and counter saturation,
// and a scoreboard that tracks every beat of the main instance in FIFO order.
module tb_ysyx_22041207_pipe_skid_stage;

   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, out_ready;
   logic [31:0] in_data;

   logic        in_ready, out_valid;
   logic [31:0] out_data;
   logic [1:0]  occupancy;
   logic [15:0] stall_cnt;

   logic        n_in_ready, n_out_valid;
   logic [31:0] n_out_data;
   logic [1:0]  n_occupancy;
   logic [15:0] n_stall_cnt;

   logic        c_in_ready, c_out_valid;
   logic [31:0] c_out_data;
   logic [1:0]  c_occupancy;
   logic [3:0]  c_stall_cnt;

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] sbq[$];

   always #5 clk = ~clk;

   ysyx_22041207_pipe_skid_stage #(.DATA_W(32), .SKID_EN(1), .CNT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .occupancy(occupancy), .stall_cnt(stall_cnt));

   ysyx_22041207_pipe_skid_stage #(.DATA_W(32), .SKID_EN(0), .CNT_W(16)) u_nosk (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(n_in_ready),
      .in_data(in_data), .out_valid(n_out_valid), .out_ready(out_ready), .out_data(n_out_data),
      .occupancy(n_occupancy), .stall_cnt(n_stall_cnt));

   ysyx_22041207_pipe_skid_stage #(.DATA_W(32), .SKID_EN(1), .CNT_W(4)) u_cnt (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
      .in_data(in_data), .out_valid(c_out_valid), .out_ready(out_ready), .out_data(c_out_data),
      .occupancy(c_occupancy), .stall_cnt(c_stall_cnt));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Scoreboard: inputs are stable at negedge, so this sees exactly what the
   // next rising edge will act on.
   always @(negedge clk) begin
      if (!rst_n || flush) begin
         sbq.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (sbq.size() == 0) chk("sb_unexpected_pop", 64'd1, 64'd0);
            else chk("sb_data", {32'd0, out_data}, {32'd0, sbq.pop_front()});
         end
         if (in_valid && in_ready) sbq.push_back(in_data);
      end
   end

   typedef struct {
      logic        iv;
      logic [31:0] id;
      logic        ordy;
      logic        fl;
      logic        ov;
      logic [31:0] od;
      logic [1:0]  occ;
      logic        ir;
      logic [15:0] st;
   } vec_t;

   vec_t tbl[17];

   task automatic drive(input logic iv, input logic [31:0] id, input logic ordy, input logic fl);
      in_valid  = iv;
      in_data   = id;
      out_ready = ordy;
      flush     = fl;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #2 rst_n = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b1;
      tick();
   endtask

   initial begin
      // streaming at full rate
      tbl[0]  = '{1'b1, 32'h1, 1'b1, 1'b0, 1'b1, 32'h1, 2'd1, 1'b1, 16'd0};
      tbl[1]  = '{1'b1, 32'h2, 1'b1, 1'b0, 1'b1, 32'h2, 2'd1, 1'b1, 16'd0};
      tbl[2]  = '{1'b1, 32'h3, 1'b1, 1'b0, 1'b1, 32'h3, 2'd1, 1'b1, 16'd0};
      tbl[3]  = '{1'b1, 32'h4, 1'b1, 1'b0, 1'b1, 32'h4, 2'd1, 1'b1, 16'd0};
      tbl[4]  = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 1'b1, 16'd0};
      // backpressure fills the skid, C waits, then drains in order
      tbl[5]  = '{1'b1, 32'hA, 1'b0, 1'b0, 1'b1, 32'hA, 2'd1, 1'b1, 16'd0};
      tbl[6]  = '{1'b1, 32'hB, 1'b0, 1'b0, 1'b1, 32'hA, 2'd2, 1'b0, 16'd1};
      tbl[7]  = '{1'b1, 32'hC, 1'b0, 1'b0, 1'b1, 32'hA, 2'd2, 1'b0, 16'd2};
      tbl[8]  = '{1'b1, 32'hC, 1'b1, 1'b0, 1'b1, 32'hB, 2'd1, 1'b1, 16'd2};
      tbl[9]  = '{1'b1, 32'hC, 1'b1, 1'b0, 1'b1, 32'hC, 2'd1, 1'b1, 16'd2};
      tbl[10] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 1'b1, 16'd2};
      // flush while FULL with a pending input
      tbl[11] = '{1'b1, 32'hA, 1'b0, 1'b0, 1'b1, 32'hA, 2'd1, 1'b1, 16'd2};
      tbl[12] = '{1'b1, 32'hB, 1'b0, 1'b0, 1'b1, 32'hA, 2'd2, 1'b0, 16'd3};
      tbl[13] = '{1'b1, 32'hC, 1'b1, 1'b1, 1'b0, 32'h0, 2'd0, 1'b1, 16'd3};
      tbl[14] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 1'b1, 16'd3};
      // flush voids a simultaneous acc and pop in ONE
      tbl[15] = '{1'b1, 32'h7, 1'b1, 1'b0, 1'b1, 32'h7, 2'd1, 1'b1, 16'd3};
      tbl[16] = '{1'b1, 32'h8, 1'b1, 1'b1, 1'b0, 32'h0, 2'd0, 1'b1, 16'd3};

      rst_n = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      #1;
      chk("rst_occ",   {62'd0, occupancy}, 64'd0);
      chk("rst_ov",    {63'd0, out_valid}, 64'd0);
      chk("rst_od",    {32'd0, out_data},  64'd0);
      chk("rst_ir",    {63'd0, in_ready},  64'd1);
      chk("rst_st",    {48'd0, stall_cnt}, 64'd0);
      chk("rst_n_ir",  {63'd0, n_in_ready}, 64'd1);
      chk("rst_c_st",  {60'd0, c_stall_cnt}, 64'd0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      tick();

      for (int i = 0; i < 17; i++) begin
         drive(tbl[i].iv, tbl[i].id, tbl[i].ordy, tbl[i].fl);
         tick();
         chk($sformatf("v%0d_ov", i),  {63'd0, out_valid}, {63'd0, tbl[i].ov});
         chk($sformatf("v%0d_od", i),  {32'd0, out_data},  {32'd0, tbl[i].od});
         chk($sformatf("v%0d_occ", i), {62'd0, occupancy}, {62'd0, tbl[i].occ});
         chk($sformatf("v%0d_ir", i),  {63'd0, in_ready},  {63'd0, tbl[i].ir});
         chk($sformatf("v%0d_st", i),  {48'd0, stall_cnt}, {48'd0, tbl[i].st});
      end
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      tick();

      // async reset mid-cycle while FULL
      drive(1'b1, 32'h11, 1'b0, 1'b0);
      tick();
      drive(1'b1, 32'h22, 1'b0, 1'b0);
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      chk("full_occ", {62'd0, occupancy}, 64'd2);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_occ", {62'd0, occupancy}, 64'd0);
      chk("arst_ov",  {63'd0, out_valid}, 64'd0);
      chk("arst_od",  {32'd0, out_data},  64'd0);
      chk("arst_ir",  {63'd0, in_ready},  64'd1);
      chk("arst_st",  {48'd0, stall_cnt}, 64'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      tick();
      drive(1'b1, 32'h5, 1'b1, 1'b0);
      tick();
      chk("post_rst_ov", {63'd0, out_valid}, 64'd1);
      chk("post_rst_od", {32'd0, out_data},  64'd5);
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      tick();
      chk("post_rst_empty", {62'd0, occupancy}, 64'd0);

      // no-skid variant: in_ready tracks out_ready while holding one beat
      drive(1'b1, 32'h9, 1'b0, 1'b0);
      tick();
      in_valid = 1'b0;
      chk("nosk_occ1", {62'd0, n_occupancy}, 64'd1);
      for (int k = 0; k < 3; k++) begin
         out_ready = 1'b0;
         #1 chk("nosk_ir_lo", {63'd0, n_in_ready}, 64'd0);
         out_ready = 1'b1;
         #1 chk("nosk_ir_hi", {63'd0, n_in_ready}, 64'd1);
         out_ready = 1'b0;
         tick();
      end
      drive(1'b1, 32'h10, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) begin
         tick();
         chk("nosk_occ_not2", {62'd0, n_occupancy}, 64'd1);
         chk("nosk_od", {32'd0, n_out_data}, 64'h9);
      end
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      repeat (4) tick();
      chk("nosk_drained", {62'd0, n_occupancy}, 64'd0);
      chk("sb_drain1", {32'd0, sbq.size()}, 64'd0);

      // stall counter saturation
      pulse_reset();
      drive(1'b1, 32'h3, 1'b0, 1'b0);
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 20; k++) tick();
      chk("sat_c_st",  {60'd0, c_stall_cnt}, 64'd15);
      chk("sat_main_st", {48'd0, stall_cnt}, 64'd20);
      tick();
      chk("sat_c_hold", {60'd0, c_stall_cnt}, 64'd15);
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      repeat (3) tick();
      chk("sat_c_keep", {60'd0, c_stall_cnt}, 64'd15);
      chk("sb_drain2", {32'd0, sbq.size()}, 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
